nibble_serial_adder_ctrl: RTL and testbench

Sequencing controller that adds two WIDTH-bit operands four bits per cycle. It reuses a single 4-bit ripple full-adder stage and a registered inter-nibble carry. It sits between an operand producer and a result consumer, using valid/ready handshakes on both sides. The trade is area for latency: one nibble adder serves any operand width.

---
 rtl/nsa_pkg.sv | 31 +++
 rtl/nsa_add4.sv | 33 +++
 rtl/nibble_serial_adder_ctrl.sv | 165 ++++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nsa_pkg
// Desc     : Shared types and constants for the nibble-serial adder controller:
//            FSM state encoding, nibble width and the index-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index counter: ceil(log2(n)) but never below 1 bit
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nsa_add4.sv
`default_nettype none
// ============================================================================
// Module   : nsa_add4
// Desc     : Purely combinational 4-bit ripple adder built from four full-adder
//            cells. Also exposes the carry into bit 3 for overflow detection.
// Revision : 1.0 - initial release
// ============================================================================
module nsa_add4
    import nsa_pkg::*;
(
    input  logic                cin,
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = cin;

    // One full-adder cell per bit, carry rippling upward
    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
    end

    assign cout = w_c[NIBBLE_W];
    assign c3   = w_c[NIBBLE_W-1];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Desc     : Adds two WIDTH-bit operands one nibble per cycle through a single
//            shared 4-bit adder and a registered inter-nibble carry, with
//            valid/ready handshakes on input and output sides.
//            Optional macro SERIAL_ADD_OVF_EN adds the signed-overflow
//            output ovf, registered alongside carryout.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NIB   = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carryin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int IDX_W = clog2(NIB);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIB - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [WIDTH-1:0]    r_x;
    logic [WIDTH-1:0]    r_y;
    logic [WIDTH-1:0]    r_sum;
    logic                r_carry;
    logic                r_cout;

    logic [NIBBLE_W-1:0] w_a;
    logic [NIBBLE_W-1:0] w_b;
    logic [NIBBLE_W-1:0] w_s;
    logic                w_nib_cout;
    logic                w_last;
`ifdef SERIAL_ADD_OVF_EN
    logic                w_c3;
    logic                r_ovf;
`else
    logic                w_unused_c3;
`endif

    // Current nibble of each operand feeds the shared adder
    assign w_a    = r_x[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_b    = r_y[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_last = (r_idx == C_LAST_IDX);

    nsa_add4 u_add4 (
        .cin  (r_carry),
        .a    (w_a),
        .b    (w_b),
        .s    (w_s),
        .cout (w_nib_cout),
`ifdef SERIAL_ADD_OVF_EN
        .c3   (w_c3)
`else
        .c3   (w_unused_c3)
`endif
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, nibble-serial accumulation and final carry/overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x     <= x;
                        r_y     <= y;
                        r_carry <= carryin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_sum[r_idx*NIBBLE_W +: NIBBLE_W] <= w_s;
                    r_carry <= w_nib_cout;
                    if (w_last) begin
                        // Park the index at 0 instead of letting it wrap
                        r_idx  <= '0;
                        r_cout <= w_nib_cout;
`ifdef SERIAL_ADD_OVF_EN
                        r_ovf  <= w_c3 ^ w_nib_cout;
`endif
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum      = r_sum;
    assign carryout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf      = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Desc     : Self-checking bench for nibble_serial_adder_ctrl. Results are
//            compared against a full-width arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             carryin = 1'b0;
    logic [WIDTH-1:0] x = '0;
    logic [WIDTH-1:0] y = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             busy;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .carryin   (carryin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carryout  (carryout),
`ifdef SERIAL_ADD_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: full-width unsigned add, carry in the top bit
    function automatic logic [WIDTH:0] model_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic c);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    endfunction

    // Reference: signed overflow when same-sign operands give other-sign result
    function automatic logic model_ovf(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input logic c);
        logic [WIDTH:0] r;
        r = model_add(a, b, c);
        return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // Present operands for one edge; returns at the negedge after the accept edge
    task automatic drive_accept(input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b,
                                input logic c);
        @(negedge clk);
        x = a; y = b; carryin = c; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Bounded wait for out_valid; n = negedges elapsed since the accept negedge
    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum got=%h exp=0", sum); end
        checks++; if (carryout !== 1'b0) begin errors++; $display("FAIL reset_carryout got=%b exp=0", carryout); end
`ifdef SERIAL_ADD_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [4] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h0000};
        logic [WIDTH-1:0] vb [4] = '{16'h4321, 16'h0001, 16'h0000, 16'h0000};
        logic             vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [WIDTH:0]   exp;
        int n;
        for (int i = 0; i < 4; i++) begin
            exp = model_add(va[i], vb[i], vc[i]);
            drive_accept(va[i], vb[i], vc[i]);
            checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL dir_run_flags[%0d] busy=%b in_ready=%b exp busy=1 in_ready=0", i, busy, in_ready); end
            wait_valid(n);
            checks++; if (n != NIB) begin errors++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, n, NIB); end
            checks++; if (sum !== exp[WIDTH-1:0]) begin errors++; $display("FAIL dir_sum[%0d] got=%h exp=%h", i, sum, exp[WIDTH-1:0]); end
            checks++; if (carryout !== exp[WIDTH]) begin errors++; $display("FAIL dir_carryout[%0d] got=%b exp=%b", i, carryout, exp[WIDTH]); end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL dir_release[%0d] out_valid=%b in_ready=%b exp 0/1", i, out_valid, in_ready); end
        end
        // Spot-check the first vector against its literal expected value
        checks++; if (model_add(16'h1234, 16'h4321, 1'b0) !== 17'h05555) begin errors++; $display("FAIL dir_model_sanity"); end
    endtask

    task automatic test_hold();
        logic [WIDTH-1:0] a, b;
        logic             c;
        logic [WIDTH:0]   exp;
        int n;
        a = WIDTH'($urandom); b = WIDTH'($urandom); c = 1'($urandom);
        exp = model_add(a, b, c);
        drive_accept(a, b, c);
        wait_valid(n);
        checks++; if (n != NIB) begin errors++; $display("FAIL hold_latency got=%0d exp=%0d", n, NIB); end
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'($urandom);
            x = WIDTH'($urandom); y = WIDTH'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== exp[WIDTH-1:0] || carryout !== exp[WIDTH]) begin
                errors++;
                $display("FAIL hold_stable[%0d] out_valid=%b in_ready=%b sum=%h cout=%b exp 1/0/%h/%b", k, out_valid, in_ready, sum, carryout, exp[WIDTH-1:0], exp[WIDTH]);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a, b;
        logic [WIDTH:0]   exp1, exp2;
        int n;
        a = WIDTH'($urandom); b = WIDTH'($urandom);
        exp1 = model_add(a, b, 1'b0);
        exp2 = model_add(16'h00FF, 16'h0F01, 1'b0);
        // out_ready high from the start: must not cut RUN short
        out_ready = 1'b1;
        drive_accept(a, b, 1'b0);
        x = 16'h00FF; y = 16'h0F01; carryin = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < NIB; k++) begin
            checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_run[%0d] busy=%b in_ready=%b out_valid=%b exp 1/0/0", k, busy, in_ready, out_valid); end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b1 || sum !== exp1[WIDTH-1:0] || carryout !== exp1[WIDTH]) begin errors++; $display("FAIL b2b_first out_valid=%b sum=%h cout=%b exp 1/%h/%b", out_valid, sum, carryout, exp1[WIDTH-1:0], exp1[WIDTH]); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        wait_valid(n);
        checks++; if (n != NIB) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", n, NIB); end
        checks++; if (sum !== exp2[WIDTH-1:0] || carryout !== exp2[WIDTH]) begin errors++; $display("FAIL b2b_second sum=%h cout=%b exp %h/%b", sum, carryout, exp2[WIDTH-1:0], exp2[WIDTH]); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        logic seen;
        logic [WIDTH:0] exp;
        int n;
        drive_accept(16'hABCD, 16'h1357, 1'b1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || carryout !== 1'b0) begin
            errors++;
            $display("FAIL abort_async in_ready=%b out_valid=%b busy=%b sum=%h cout=%b exp 1/0/0/0000/0", in_ready, out_valid, busy, sum, carryout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < NIB + 3; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_valid got=%b exp=0", seen); end
        exp = model_add(16'h0F0F, 16'h00F1, 1'b0);
        drive_accept(16'h0F0F, 16'h00F1, 1'b0);
        wait_valid(n);
        checks++; if (n != NIB || sum !== exp[WIDTH-1:0] || carryout !== exp[WIDTH]) begin errors++; $display("FAIL abort_recover lat=%0d sum=%h cout=%b exp %0d/%h/%b", n, sum, carryout, NIB, exp[WIDTH-1:0], exp[WIDTH]); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        logic             c;
        logic [WIDTH:0]   exp;
        int n, stall;
        for (int i = 0; i < 25; i++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); c = 1'($urandom);
            if (i % 5 == 0) a = '1;
            exp = model_add(a, b, c);
            drive_accept(a, b, c);
            wait_valid(n);
            checks++; if (n != NIB) begin errors++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", i, n, NIB); end
            checks++; if (sum !== exp[WIDTH-1:0] || carryout !== exp[WIDTH]) begin errors++; $display("FAIL rnd_result[%0d] a=%h b=%h c=%b sum=%h cout=%b exp %h/%b", i, a, b, c, sum, carryout, exp[WIDTH-1:0], exp[WIDTH]); end
`ifdef SERIAL_ADD_OVF_EN
            checks++; if (ovf !== model_ovf(a, b, c)) begin errors++; $display("FAIL rnd_ovf[%0d] got=%b exp=%b", i, ovf, model_ovf(a, b, c)); end
`endif
            stall = $urandom_range(0, 3);
            repeat (stall) @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_release[%0d] got=%b exp=0", i, out_valid); end
        end
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task automatic test_ovf();
        int n;
        drive_accept(16'h7FFF, 16'h0001, 1'b0);
        wait_valid(n);
        checks++; if (ovf !== 1'b1 || carryout !== 1'b0) begin errors++; $display("FAIL ovf_pos ovf=%b cout=%b exp 1/0", ovf, carryout); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
        drive_accept(16'hFFFF, 16'h0001, 1'b0);
        wait_valid(n);
        checks++; if (ovf !== 1'b0 || carryout !== 1'b1) begin errors++; $display("FAIL ovf_wrap ovf=%b cout=%b exp 0/1", ovf, carryout); end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_abort();
        test_random();
`ifdef SERIAL_ADD_OVF_EN
        test_ovf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net against a stuck run
    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
